// File: rtl/pipe_pkg.sv
// Shared types and constants for the inter-stage pipeline register.
// Stage code slices out_ctrl by name using the per-boundary bit indices below.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    localparam int unsigned PIPE_CTRL_W_DEF = 8;
    localparam int unsigned PIPE_DATA_W_DEF = 128;

    // IF/ID boundary control fields
    localparam int unsigned IFID_PRED_TAKEN  = 0;
    localparam int unsigned IFID_EXC         = 1;

    // ID/EX boundary control fields
    localparam int unsigned IDEX_WB          = 0;
    localparam int unsigned IDEX_MEM_READ    = 1;
    localparam int unsigned IDEX_MEM_WRITE   = 2;
    localparam int unsigned IDEX_BRANCH      = 3;
    localparam int unsigned IDEX_S           = 4;
    localparam int unsigned IDEX_ALU_SRC     = 5;

    // EX/MEM boundary control fields
    localparam int unsigned EXMEM_WB         = 0;
    localparam int unsigned EXMEM_MEM_READ   = 1;
    localparam int unsigned EXMEM_MEM_WRITE  = 2;
    localparam int unsigned EXMEM_BRANCH     = 3;

    // MEM/WB boundary control fields
    localparam int unsigned MEMWB_WB         = 0;
    localparam int unsigned MEMWB_MEM_TO_REG = 1;

    // One-hot mask for a named control field, for building/decoding ctrl words.
    function automatic logic [PIPE_CTRL_W_DEF-1:0] ctrl_mask(input int unsigned idx);
        logic [PIPE_CTRL_W_DEF-1:0] m;
        m = '0;
        m[idx[$clog2(PIPE_CTRL_W_DEF)-1:0]] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// One pipeline slot: valid flag plus control and data words.
// Flush beats load and clear; ctrl always zeroes on flush, data only when CLEAR_DATA != 0.
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W     = PIPE_CTRL_W_DEF,
    parameter int unsigned DATA_W     = PIPE_DATA_W_DEF,
    parameter int unsigned CLEAR_DATA = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [DATA_W-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            if (CLEAR_DATA != 0) begin
                data_d = '0;
            end
        end else if (load_i) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_i;
            data_d  = data_i;
        end else if (clear_i) begin
            // Data is left in place on release; only the enables are killed.
            valid_d = 1'b0;
            ctrl_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register between two stages, with synchronous flush.
// Define PIPE_STAGE_REG_SKID_EN for a two-entry skid buffer with a registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W     = PIPE_CTRL_W_DEF,
    parameter int unsigned DATA_W     = PIPE_DATA_W_DEF,
    parameter int unsigned CLEAR_DATA = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
);

    logic              acc_fire;
    logic              rel_fire;
    logic              head_load;
    logic              head_clear;
    logic              head_valid;
    logic [CTRL_W-1:0] head_ctrl;
    logic [DATA_W-1:0] head_data;
    logic [CTRL_W-1:0] head_ctrl_in;
    logic [DATA_W-1:0] head_data_in;

    assign acc_fire = in_valid && in_ready;
    assign rel_fire = head_valid && out_ready;

`ifdef PIPE_STAGE_REG_SKID_EN
    pipe_state_t       state_q, state_d;
    logic              in_ready_q;
    logic              skid_load;
    logic              skid_clear;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    always_comb begin
        state_d    = state_q;
        head_load  = 1'b0;
        head_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        case (state_q)
            EMPTY: begin
                if (acc_fire) begin
                    head_load = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (acc_fire && rel_fire) begin
                    head_load = 1'b1;
                end else if (acc_fire) begin
                    skid_load = 1'b1;
                    state_d   = FULL;
                end else if (rel_fire) begin
                    head_clear = 1'b1;
                    state_d    = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only a release can happen.
                if (rel_fire) begin
                    head_load  = 1'b1;
                    skid_clear = 1'b1;
                    state_d    = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    assign in_ready = in_ready_q;

    // The skid slot is only ever valid in FULL, which is exactly when the head refills from it.
    assign head_ctrl_in = skid_valid ? skid_ctrl : in_ctrl;
    assign head_data_in = skid_valid ? skid_data : in_data;

    pipe_entry #(
        .CTRL_W     (CTRL_W),
        .DATA_W     (DATA_W),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .ctrl_i  (in_ctrl),
        .data_i  (in_data),
        .valid_o (skid_valid),
        .ctrl_o  (skid_ctrl),
        .data_o  (skid_data)
    );
`else
    assign in_ready     = !head_valid || out_ready;
    assign head_load    = acc_fire;
    assign head_clear   = rel_fire && !acc_fire;
    assign head_ctrl_in = in_ctrl;
    assign head_data_in = in_data;
`endif

    pipe_entry #(
        .CTRL_W     (CTRL_W),
        .DATA_W     (DATA_W),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_head (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .load_i  (head_load),
        .clear_i (head_clear),
        .ctrl_i  (head_ctrl_in),
        .data_i  (head_data_in),
        .valid_o (head_valid),
        .ctrl_o  (head_ctrl),
        .data_o  (head_data)
    );

    assign out_valid = head_valid;
    // A bubble must never present live enables downstream.
    assign out_ctrl  = head_valid ? head_ctrl : '0;
    assign out_data  = head_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed table plus corner-case sequences and a random scoreboard run for pipe_stage_reg.
// Two instances share stimulus: CLEAR_DATA=1 (main) and CLEAR_DATA=0 (data kept on flush).
module tb_pipe_stage_reg;

    localparam int CW = 8;
    localparam int DW = 16;
`ifdef PIPE_STAGE_REG_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;

    logic          in_ready, out_valid;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic          in_ready0, out_valid0;
    logic [CW-1:0] out_ctrl0;
    logic [DW-1:0] out_data0;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(0)) dut_keep (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0), .out_data(out_data0)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic          v, r, f;
        logic [CW-1:0] c;
        logic [DW-1:0] d;
        logic          ck_rdy, e_rdy;
        logic          e_v;
        logic [CW-1:0] e_c;
        logic [DW-1:0] e_d;
        logic [DW-1:0] e_d0;
    } vec_t;

    vec_t          tbl [14];
    logic [23:0]   src_q [$];
    logic [23:0]   sb_q [$];
    bit            acc, rel;
    logic [23:0]   exp_beat;

    localparam logic [23:0] BA = 24'hA1_0AAA;
    localparam logic [23:0] BB = 24'hB2_0BBB;
    localparam logic [23:0] BC = 24'hC3_0CCC;
    localparam logic [23:0] BE = 24'hE5_0EEE;
    localparam logic [23:0] BX = 24'h99_9999;

    function automatic vec_t mk(logic v, logic r, logic f, logic [CW-1:0] c, logic [DW-1:0] d,
                                logic ck, logic er, logic ev, logic [CW-1:0] ec,
                                logic [DW-1:0] ed, logic [DW-1:0] ed0);
        vec_t t;
        t.v = v; t.r = r; t.f = f; t.c = c; t.d = d;
        t.ck_rdy = ck; t.e_rdy = er; t.e_v = ev; t.e_c = ec; t.e_d = ed; t.e_d0 = ed0;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_src();
        if (src_q.size() > 0) begin
            in_valid = 1'b1;
            {in_ctrl, in_data} = src_q[0];
        end else begin
            in_valid = 1'b0;
        end
    endtask

    // One clock with the source queue: a beat leaves the queue only if it was accepted.
    task automatic cycle();
        #1;
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (acc && src_q.size() > 0) void'(src_q.pop_front());
        drive_src();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        src_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    function automatic logic [31:0] head_word();
        return 32'({out_valid, out_ctrl, out_data});
    endfunction

    initial begin
        //             v r f ctrl   data      ck er  ev ctrl   data      data(keep)
        tbl[0]  = mk(0,1,0,8'h00,16'h0000, 1,1,  0,8'h00,16'h0000,16'h0000);
        tbl[1]  = mk(0,1,0,8'h00,16'h0000, 1,1,  0,8'h00,16'h0000,16'h0000);
        tbl[2]  = mk(1,1,0,8'h5A,16'h1234, 1,1,  1,8'h5A,16'h1234,16'h1234);
        tbl[3]  = mk(0,1,0,8'h00,16'h0000, 1,1,  0,8'h00,16'h1234,16'h1234);
        tbl[4]  = mk(1,1,0,8'h11,16'hA001, 1,1,  1,8'h11,16'hA001,16'hA001);
        tbl[5]  = mk(1,1,0,8'h22,16'hB002, 1,1,  1,8'h22,16'hB002,16'hB002);
        tbl[6]  = mk(1,1,1,8'h33,16'hC003, 1,1,  0,8'h00,16'h0000,16'hB002);
        tbl[7]  = mk(1,1,0,8'h44,16'hD004, 1,1,  1,8'h44,16'hD004,16'hD004);
        tbl[8]  = mk(0,0,0,8'h00,16'h0000, 0,0,  1,8'h44,16'hD004,16'hD004);
        tbl[9]  = mk(0,0,0,8'h00,16'h0000, 0,0,  1,8'h44,16'hD004,16'hD004);
        tbl[10] = mk(0,1,0,8'h00,16'h0000, 1,1,  0,8'h00,16'hD004,16'hD004);
        tbl[11] = mk(1,1,0,8'hFF,16'hFFFF, 1,1,  1,8'hFF,16'hFFFF,16'hFFFF);
        tbl[12] = mk(0,0,1,8'h00,16'h0000, 0,0,  0,8'h00,16'h0000,16'hFFFF);
        tbl[13] = mk(1,0,0,8'h01,16'h0001, 1,1,  1,8'h01,16'h0001,16'h0001);

        // Reset state while rst is held low
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_head", head_word(), 32'h0);
        chk("reset_in_ready", 32'(in_ready), 32'h1);
        rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            in_valid  = tbl[i].v;
            out_ready = tbl[i].r;
            flush     = tbl[i].f;
            in_ctrl   = tbl[i].c;
            in_data   = tbl[i].d;
            #1;
            if (tbl[i].ck_rdy) chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_v));
            chk($sformatf("vec%0d_out_ctrl", i), 32'(out_ctrl), 32'(tbl[i].e_c));
            chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_d));
            chk($sformatf("vec%0d_keep_valid", i), 32'(out_valid0), 32'(tbl[i].e_v));
            chk($sformatf("vec%0d_keep_data", i), 32'(out_data0), 32'(tbl[i].e_d0));
        end
        flush = 1'b0;
        in_valid = 1'b0;

        // Backpressure: A,B,C offered with out_ready low, then released
        do_reset();
        src_q = '{BA, BB, BC};
        drive_src();
        cycle();
        chk("bp_c1_head", head_word(), 32'({1'b1, BA}));
        chk("bp_c1_in_ready", 32'(in_ready), 32'(SKID));
        cycle();
        chk("bp_c2_head", head_word(), 32'({1'b1, BA}));
        chk("bp_c2_in_ready", 32'(in_ready), 32'h0);
        cycle();
        chk("bp_c3_head", head_word(), 32'({1'b1, BA}));
        out_ready = 1'b1;
        cycle();
        chk("bp_c4_head", head_word(), 32'({1'b1, BB}));
        cycle();
        chk("bp_c5_head", head_word(), 32'({1'b1, BC}));
        cycle();
        chk("bp_c6_head", head_word(), 32'({1'b0, BC[23:16] & 8'h00, BC[15:0]}));

        // Flush while holding A (and B in skid mode), beat X offered in the flush cycle
        do_reset();
        src_q = '{BA, BB};
        drive_src();
        cycle();
        cycle();
        src_q.delete();
        in_valid = 1'b1;
        {in_ctrl, in_data} = BX;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_head", head_word(), 32'h0);
        chk("flush_keep_ctrl", 32'(out_ctrl0), 32'h0);
        chk("flush_keep_data", 32'(out_data0), 32'(BA[15:0]));
        chk("flush_in_ready", 32'(in_ready), 32'h1);
        out_ready = 1'b1;
        cycle();
        chk("flush_after1_valid", 32'(out_valid), 32'h0);
        cycle();
        chk("flush_after2_valid", 32'(out_valid), 32'h0);

        // Asynchronous reset between edges while holding beats, then beat E
        do_reset();
        src_q = '{BA, BB};
        drive_src();
        cycle();
        cycle();
        #2;
        rst = 1'b0;
        #1;
        chk("rstmid_head", head_word(), 32'h0);
        chk("rstmid_in_ready", 32'(in_ready), 32'h1);
        chk("rstmid_keep_head", 32'({out_valid0, out_ctrl0, out_data0}), 32'h0);
        chk("rstmid_keep_in_ready", 32'(in_ready0), 32'h1);
        #2;
        rst = 1'b1;
        src_q = '{BE};
        out_ready = 1'b1;
        drive_src();
        cycle();
        chk("rstmid_e_head", head_word(), 32'({1'b1, BE}));
        cycle();
        chk("rstmid_e_gone", 32'(out_valid), 32'h0);

        // Random valid/ready with scoreboard
        do_reset();
        for (int i = 0; i < 10004; i++) begin
            if (i < 10000) begin
                in_valid  = 1'($urandom_range(0, 1));
                in_ctrl   = 8'($urandom);
                in_data   = 16'($urandom);
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            acc = in_valid && in_ready;
            rel = out_valid && out_ready;
            if (rel) begin
                if (sb_q.size() == 0) begin
                    chk("rnd_spurious_release", 32'h1, 32'h0);
                end else begin
                    exp_beat = sb_q.pop_front();
                    chk($sformatf("rnd_release_c%0d", i), 32'({out_ctrl, out_data}), 32'(exp_beat));
                end
            end
            if (!out_valid) chk($sformatf("rnd_bubble_ctrl_c%0d", i), 32'(out_ctrl), 32'h0);
            if (acc) sb_q.push_back({in_ctrl, in_data});
            @(posedge clk);
            #1;
        end
        chk("rnd_leftover", 32'(sb_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register that replaces the fixed-field ID/EX-style latches. It carries an arbitrary control word and data word between two pipeline stages under a valid/ready handshake, with a synchronous flush that kills in-flight control. An optional two-entry skid mode registers `in_ready` so timing paths are cut without losing throughput. One instance sits on every stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface

- `CTRL_W`, default 8: control word width. Enables such as wb/mem_read/mem_write/branch/S; always zeroed on flush.
- `DATA_W`, default 128: data word width. Operands, PC, immediates, dest, status.
- `CLEAR_DATA`, default 1: 1 zeroes data on flush; 0 leaves data unchanged on flush.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous kill of all held entries.
- `in_valid` in 1: upstream beat valid.
- `in_ready` out 1: stage can accept a beat.
- `in_ctrl` in CTRL_W: upstream control word.
- `in_data` in DATA_W: upstream data word.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: downstream accepts the head entry.
- `out_ctrl` out CTRL_W: head control word. Zero whenever `out_valid`=0.
- `out_data` out DATA_W: head data word.

## Operation

- Accept: `in_valid && in_ready` at a rising edge. Release: `out_valid && out_ready` at a rising edge.
- Entries leave strictly in arrival order. No beat is duplicated or dropped, except by flush.
- Reset (`rst`=0, asynchronous): all entries invalid, `out_valid`=0, `out_ctrl`=0, `out_data`=0, `in_ready`=1.
- Flush has priority over every other event in the same cycle. At the next edge:
  - all entries are invalidated and every ctrl register is zeroed;
  - data registers are zeroed if `CLEAR_DATA`=1;
  - a beat accepted in the flush cycle is discarded.
- Simultaneous accept and release with one held entry: the new beat replaces the head, and `out_valid` stays 1.
- Release with no accept: the head empties, or the skid entry moves up to the head in skid mode.
- `out_ctrl` is gated to zero when the head entry is invalid, so a bubble never carries live enables.

## Timing

- Latency: beat accepted at edge N appears on `out_*` after edge N, i.e. one cycle.
- Throughput: one beat per cycle while `out_ready`=1, in both modes.
- Without skid mode, `in_ready` = `!out_valid || out_ready`. This is a combinational path from `out_ready`.
- With skid mode, `in_ready` is a flop output with no combinational input-to-output path.
- Stall behaviour: `out_valid`, `out_ctrl` and `out_data` remain stable while `out_valid && !out_ready`.
- Reset mid-transfer: the state clears immediately. The first accept is possible at the first edge after `rst` deasserts.

## Configuration

- `PIPE_STAGE_REG_SKID_EN` defined: two entries (head + skid). State machine:
  - EMPTY→ONE on accept.
  - ONE→ONE on accept+release, or on idle.
  - ONE→EMPTY on release only.
  - ONE→FULL on accept while stalled.
  - FULL→ONE on release; the skid entry moves to the head.
  - Any state→EMPTY on flush.
  - `in_ready` = (next state ≠ FULL), registered.
  - FULL is entered only from ONE with `in_ready`=1, so a third beat is never accepted.
- Macro undefined: single head entry, no state register, combinational `in_ready` as given under Timing.

## Structure

- Package `pipe_pkg`:
  - enum `pipe_state_t` {EMPTY, ONE, FULL};
  - localparams for default `CTRL_W`/`DATA_W`;
  - a per-boundary ctrl-field bit-index constant set, so stage code slices `out_ctrl` by name.
- Sub-module `pipe_entry`: one valid+ctrl+data slot with load, clear, flush and `CLEAR_DATA` handling. Instantiated once, or twice in skid mode.

## Test plan

- Pass-through: `out_ready`=1 and ctrl 0x5A/data 0x1234 accepted at edge 3 → `out_valid`=1 with 0x5A/0x1234 after edge 3, gone after edge 4.
- Backpressure: hold `out_ready`=0 with beats A,B,C offered.
  - Skid: A and B accepted, `in_ready`=0 after edge 2, C held upstream. On release, out order is A,B,C with no gaps.
  - Non-skid: only A is held.
- Flush: FULL with A,B and `flush`=1 → `out_valid`=0 and `out_ctrl`=0 next cycle; `out_data`=0 with `CLEAR_DATA`=1, unchanged with `CLEAR_DATA`=0. A beat offered in the flush cycle never appears.
- Simultaneous: ONE holding A, accept D while `out_ready`=1 → D at head next cycle, `out_valid` uninterrupted.
- Reset mid-op: drive `rst`=0 asynchronously between edges while FULL → outputs zero and `in_ready`=1 before the next edge. After release, beat E passes with 1-cycle latency.
- Random valid/ready toggling over 10k cycles with a scoreboard → in-order, lossless delivery in both macro settings.
